// File: rtl/snap_ctrl_pkg.sv
// Shared types and bit positions for the snapshot capture controller.
package snap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int ARM_BIT       = 0;
    localparam int TRIG_IMM_BIT  = 1;
    localparam int IGN_VALID_BIT = 2;

    localparam int DONE_BIT = 31;
    localparam int BUSY_BIT = 30;

    function automatic logic is_busy(input state_t s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/snap_edge_det.sv
// Single-bit rising-edge detector; the first clock after reset only loads history,
// so a level already high at reset release never looks like an edge.
module snap_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev;
    logic primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= 1'b0;
            primed <= 1'b0;
        end else begin
            prev   <= sig;
            primed <= 1'b1;
        end
    end

    assign rise = primed & sig & ~prev;

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arms from a software rising edge, waits for a trigger,
// then fills a 2**ADDR_W-word buffer once and reports done/busy/count.
module snap_capture_ctrl
    import snap_ctrl_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_reg,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trig,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status_out
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    state_t          state;
    logic [ADDR_W:0] count;
    logic            arm;
    logic            trig_hit;
    logic            cap_cycle;
    logic            wr;
    logic [31:0]     status_next;
    logic            unused_ctrl;

    assign unused_ctrl = ^ctrl_reg[31:3];

    snap_edge_det u_arm_edge (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .sig   (ctrl_reg[ARM_BIT]),
        .rise  (arm)
    );

    // An arm event pre-empts everything else, including a capture write in that cycle.
    assign trig_hit  = trig | ctrl_reg[TRIG_IMM_BIT];
    assign cap_cycle = !arm && ((state == ST_CAPTURE) || (state == ST_ARMED && trig_hit));
    assign wr        = cap_cycle && (din_valid || ctrl_reg[IGN_VALID_BIT]);

    always_comb begin
        status_next             = '0;
        status_next[ADDR_W:0]   = count;
        status_next[DONE_BIT]   = (state == ST_DONE);
        status_next[BUSY_BIT]   = is_busy(state);
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            bram_addr  <= '0;
            bram_data  <= '0;
            bram_we    <= 1'b0;
            status_out <= '0;
        end else begin
            status_out <= status_next;
            bram_we    <= wr;
            if (wr) begin
                bram_addr <= count[ADDR_W-1:0];
                bram_data <= din;
                count     <= count + 1'b1;
            end
            if (arm) begin
                state <= ST_ARMED;
                count <= '0;
            end else begin
                case (state)
                    ST_ARMED:   if (trig_hit) state <= ST_CAPTURE;
                    default:    ;
                endcase
                // The last address fills the buffer; count is left at 2**ADDR_W.
                if (wr && count == LAST_ADDR) state <= ST_DONE;
            end
        end
    end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl (ADDR_W=4): expected writes go into a queue
// that a negedge monitor drains; status is checked against hand-computed words.
module tb_snap_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int EW     = ADDR_W + DATA_W;

    logic              clk;
    logic              rst_n;
    logic [31:0]       ctrl_reg;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              trig;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status_out;

    logic [EW-1:0] exp_q[$];
    int total;
    int bad;

    snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .ctrl_reg   (ctrl_reg),
        .din        (din),
        .din_valid  (din_valid),
        .trig       (trig),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .bram_we    (bram_we),
        .status_out (status_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [DATA_W-1:0] data);
        logic [ADDR_W-1:0] a;
        a = addr[ADDR_W-1:0];
        exp_q.push_back({a, data});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        ctrl_reg  = '0;
        din       = '0;
        din_valid = 1'b0;
        trig      = 1'b0;

        // scoreboard monitor: every observed write must match the queue head
        fork
            forever begin
                @(negedge clk);
                if (rst_n && bram_we) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write: addr=%0d data=0x%08h, no write expected",
                                 bram_addr, bram_data);
                    end else begin
                        logic [EW-1:0] e;
                        e = exp_q.pop_front();
                        if ({bram_addr, bram_data} !== e) begin
                            bad++;
                            $display("FAIL write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                                     bram_addr, bram_data, e[EW-1:DATA_W], e[DATA_W-1:0]);
                        end
                    end
                end
            end
        join_none

        #12;
        check("reset_status", status_out, 32'h0);
        check("reset_we", {31'b0, bram_we}, 32'h0);
        rst_n = 1'b1;
        tick(); tick();

        // immediate-trigger full capture with a ramp
        ctrl_reg = 32'h3; din_valid = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            din = k;
            push(k, k);
            tick();
            if (k == 2) check("busy_mid_capture", status_out, 32'h4000_0002);
        end
        trig = 1'b1;
        tick(); tick(); tick();
        check("done_status", status_out, 32'h8000_0010);
        check("done_no_we", {31'b0, bram_we}, 32'h0);
        ctrl_reg = 32'h0; trig = 1'b0;
        tick();

        // arm together with trig in DONE only arms; external trigger later
        ctrl_reg = 32'h1; trig = 1'b1;
        tick();
        check("arm_clears_done", status_out, 32'h8000_0010);
        trig = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din = 100 + i;
            tick();
        end
        check("armed_waiting", status_out, 32'h4000_0000);
        trig = 1'b1; din = 32'hAAAA; push(0, 32'hAAAA);
        tick();
        trig = 1'b0;
        din = 32'h11; din_valid = 1'b0; tick();
        din = 32'h22; din_valid = 1'b1; push(1, 32'h22); tick();
        din = 32'h33; din_valid = 1'b0; tick();
        din = 32'h44; din_valid = 1'b1; push(2, 32'h44); tick();
        ctrl_reg = 32'h4; din_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            din = 32'h50 + j;
            push(3 + j, 32'h50 + j);
            tick();
        end
        check("count_before_rearm", status_out, 32'h4000_0006);

        // re-arm at count 7 aborts without writing
        ctrl_reg = 32'h5; din = 32'hDEAD; din_valid = 1'b1;
        tick();
        check("rearm_cycle_status", status_out, 32'h4000_0007);
        ctrl_reg = 32'h1;
        tick();
        check("rearm_count_zero", status_out, 32'h4000_0000);
        trig = 1'b1; din = 32'h77; push(0, 32'h77); tick();
        trig = 1'b0; din = 32'h78; push(1, 32'h78); tick();

        // reset mid-capture with bit0 held
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_we", {31'b0, bram_we}, 32'h0);
        check("rst_addr", {28'b0, bram_addr}, 32'h0);
        check("rst_data", bram_data, 32'h0);
        check("rst_status", status_out, 32'h0);
        tick(); tick();
        rst_n = 1'b1; trig = 1'b1; din_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("no_arm_after_rst", status_out, 32'h0);
        trig = 1'b0; ctrl_reg = 32'h0; tick();
        ctrl_reg = 32'h1; tick(); tick();
        check("arm_after_toggle", status_out, 32'h4000_0000);

        // arm and trig together in IDLE; bit0 held high for 100 cycles
        rst_n = 1'b0; ctrl_reg = 32'h0; tick();
        rst_n = 1'b1; tick(); tick();
        ctrl_reg = 32'h1; trig = 1'b1; din = 32'h99; din_valid = 1'b1;
        tick();
        trig = 1'b0;
        tick(); tick(); tick();
        check("idle_arm_trig", status_out, 32'h4000_0000);
        trig = 1'b1; din = 32'h100; push(0, 32'h100); tick();
        trig = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            din_valid = (i % 10 == 0);
            din = 32'h200 + i;
            if (i % 10 == 0) push(i / 10, 32'h200 + i);
            tick();
        end
        din_valid = 1'b0;
        tick(); tick();
        check("held_arm_count", status_out, 32'h4000_000B);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
